// File: rtl/bsg_mesh_pkt_injector.sv
// Burst packet source for a mesh router P port: turns burst commands into
// packets stamped with this node's coordinate, held stable until yumi.
module bsg_mesh_pkt_injector #(
  parameter int unsigned DATA_WIDTH_P   = 4,
  parameter int unsigned X_CORD_WIDTH_P = 1,
  parameter int unsigned Y_CORD_WIDTH_P = 1,
  parameter int unsigned MY_X_P         = 0,
  parameter int unsigned MY_Y_P         = 0,
  parameter int unsigned COUNT_WIDTH_P  = 8,
  parameter int unsigned GAP_WIDTH_P    = 4
) (
  input  logic                                      clk,
  input  logic                                      reset_n,
  input  logic                                      cmd_v_i,
  output logic                                      cmd_ready_o,
  input  logic [X_CORD_WIDTH_P+Y_CORD_WIDTH_P-1:0]  cmd_dest_i,
  input  logic [COUNT_WIDTH_P-1:0]                  cmd_count_i,
  input  logic [DATA_WIDTH_P-1:0]                   cmd_payload_i,
  input  logic [GAP_WIDTH_P-1:0]                    cmd_gap_i,
  output logic                                      v_o,
  output logic [2*(X_CORD_WIDTH_P+Y_CORD_WIDTH_P)+DATA_WIDTH_P-1:0] data_o,
  input  logic                                      yumi_i,
  output logic                                      busy_o,
  output logic                                      done_o,
  output logic [15:0]                               sent_total_o
);

  localparam int unsigned CORD_W = X_CORD_WIDTH_P + Y_CORD_WIDTH_P;
  localparam logic [X_CORD_WIDTH_P-1:0] MY_X = X_CORD_WIDTH_P'(MY_X_P);
  localparam logic [Y_CORD_WIDTH_P-1:0] MY_Y = Y_CORD_WIDTH_P'(MY_Y_P);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_e;

  state_e                   state_r, state_n;
  logic [CORD_W-1:0]        dest_r;
  logic [COUNT_WIDTH_P-1:0] remaining_r;
  logic [DATA_WIDTH_P-1:0]  payload_r;
  logic [GAP_WIDTH_P-1:0]   gap_r;
  logic [GAP_WIDTH_P-1:0]   gap_cnt_r;
  logic [15:0]              sent_total_r;
  logic                     done_r;
  logic                     fire;
  logic                     consume;
  logic                     last;

  assign fire    = (state_r == IDLE) && cmd_v_i;
  assign consume = (state_r == SEND) && yumi_i;
  assign last    = consume && (remaining_r == COUNT_WIDTH_P'(1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_r <= IDLE;
    else          state_r <= state_n;
  end

  always_comb begin
    state_n = state_r;
    unique case (state_r)
      IDLE: if (cmd_v_i && (cmd_count_i != '0)) state_n = SEND;
      SEND: if (yumi_i) begin
              if (remaining_r == COUNT_WIDTH_P'(1)) state_n = IDLE;
              else if (gap_r != '0)                state_n = GAP;
            end
      GAP:  if (gap_cnt_r == GAP_WIDTH_P'(1)) state_n = SEND;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dest_r       <= '0;
      remaining_r  <= '0;
      payload_r    <= '0;
      gap_r        <= '0;
      gap_cnt_r    <= '0;
      sent_total_r <= '0;
      done_r       <= 1'b0;
    end else begin
      done_r <= (fire && (cmd_count_i == '0)) || last;
      if (fire) begin
        dest_r      <= cmd_dest_i;
        remaining_r <= cmd_count_i;
        payload_r   <= cmd_payload_i;
        gap_r       <= cmd_gap_i;
      end
      if (consume) begin
        remaining_r  <= remaining_r - 1'b1;
        payload_r    <= payload_r + 1'b1;
        sent_total_r <= sent_total_r + 16'd1;
        gap_cnt_r    <= gap_r;
      end
      if (state_r == GAP) gap_cnt_r <= gap_cnt_r - 1'b1;
    end
  end

  // Outputs decode registered state only, so yumi_i never reaches v_o/data_o
  // combinationally and an async reset drops v_o at once.
  assign v_o          = (state_r == SEND);
  assign data_o       = v_o ? {MY_Y, MY_X, payload_r, dest_r} : '0;
  assign busy_o       = (state_r != IDLE);
  assign cmd_ready_o  = (state_r == IDLE) && reset_n;
  assign done_o       = done_r;
  assign sent_total_o = sent_total_r;

endmodule

// File: tb/tb_bsg_mesh_pkt_injector.sv
// Self-checking bench for bsg_mesh_pkt_injector: directed bursts plus random
// bursts checked against a transaction-level packet/gap model.
module tb_bsg_mesh_pkt_injector;

  localparam int unsigned DW = 4;
  localparam int unsigned CW = 2;
  localparam int unsigned MYX = 1;
  localparam int unsigned MYY = 0;
  localparam int unsigned SRC = MYY * 2 + MYX;

  logic        clk;
  logic        reset_n;
  logic        cmd_v_i;
  logic        cmd_ready_o;
  logic [1:0]  cmd_dest_i;
  logic [7:0]  cmd_count_i;
  logic [3:0]  cmd_payload_i;
  logic [3:0]  cmd_gap_i;
  logic        v_o;
  logic [7:0]  data_o;
  logic        yumi_i;
  logic        busy_o;
  logic        done_o;
  logic [15:0] sent_total_o;

  int unsigned checks;
  int unsigned errors;
  int unsigned model_total;

  bsg_mesh_pkt_injector #(
    .DATA_WIDTH_P   (DW),
    .X_CORD_WIDTH_P (1),
    .Y_CORD_WIDTH_P (1),
    .MY_X_P         (MYX),
    .MY_Y_P         (MYY),
    .COUNT_WIDTH_P  (8),
    .GAP_WIDTH_P    (4)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .cmd_v_i       (cmd_v_i),
    .cmd_ready_o   (cmd_ready_o),
    .cmd_dest_i    (cmd_dest_i),
    .cmd_count_i   (cmd_count_i),
    .cmd_payload_i (cmd_payload_i),
    .cmd_gap_i     (cmd_gap_i),
    .v_o           (v_o),
    .data_o        (data_o),
    .yumi_i        (yumi_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .sent_total_o  (sent_total_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pkt(input int unsigned pay, input int unsigned dst);
    return 32'(SRC * (1 << (DW + CW)) + (pay % (1 << DW)) * (1 << CW) + dst);
  endfunction

  // mode 0: yumi always high; 1: random yumi and stray commands; 2: stall 5 then high
  task automatic run_burst(input int unsigned dst, input int unsigned cnt,
                           input int unsigned pay, input int unsigned gp,
                           input int unsigned mode);
    int unsigned idx   = 0;
    int unsigned waitc = 0;
    int unsigned stall = 0;
    int unsigned cyc   = 0;
    logic ev;
    logic yu;
    chk("idle_ready", 32'(cmd_ready_o), 1);
    chk("idle_busy", 32'(busy_o), 0);
    cmd_v_i       = 1'b1;
    cmd_dest_i    = 2'(dst);
    cmd_count_i   = 8'(cnt);
    cmd_payload_i = 4'(pay);
    cmd_gap_i     = 4'(gp);
    yumi_i        = (mode == 0);
    @(negedge clk);
    cmd_v_i = 1'b0;
    if (cnt == 0) begin
      chk("zero_done", 32'(done_o), 1);
      chk("zero_busy", 32'(busy_o), 0);
      chk("zero_v", 32'(v_o), 0);
      chk("zero_total", 32'(sent_total_o), model_total % 65536);
      yumi_i = 1'b0;
      @(negedge clk);
      chk("zero_done_clr", 32'(done_o), 0);
      chk("zero_busy2", 32'(busy_o), 0);
      return;
    end
    while (idx < cnt && cyc < 2000) begin
      ev = (waitc == 0);
      chk("v_o", 32'(v_o), 32'(ev));
      chk("busy", 32'(busy_o), 1);
      chk("ready_busy", 32'(cmd_ready_o), 0);
      chk("done_mid", 32'(done_o), 0);
      chk("total", 32'(sent_total_o), model_total % 65536);
      if (ev) chk("data_o", 32'(data_o), pkt(pay + idx, dst));
      case (mode)
        0:       yu = 1'b1;
        1:       yu = ($urandom_range(0, 99) < 60);
        default: yu = ev && (stall >= 5);
      endcase
      if (mode == 2 && ev && !yu) stall++;
      yumi_i = yu;
      if (mode == 1) begin
        cmd_v_i       = 1'($urandom_range(0, 1));
        cmd_dest_i    = 2'($urandom_range(0, 3));
        cmd_count_i   = 8'($urandom_range(0, 255));
        cmd_payload_i = 4'($urandom_range(0, 15));
        cmd_gap_i     = 4'($urandom_range(0, 15));
      end
      if (ev && yu) begin
        idx++;
        model_total++;
        waitc = gp;
      end else if (waitc > 0) begin
        waitc--;
      end
      cyc++;
      @(negedge clk);
    end
    cmd_v_i = 1'b0;
    yumi_i  = 1'b0;
    chk("burst_complete", idx, cnt);
    chk("end_done", 32'(done_o), 1);
    chk("end_v", 32'(v_o), 0);
    chk("end_busy", 32'(busy_o), 0);
    chk("end_ready", 32'(cmd_ready_o), 1);
    chk("end_total", 32'(sent_total_o), model_total % 65536);
    @(negedge clk);
    chk("done_clr", 32'(done_o), 0);
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    model_total   = 0;
    reset_n       = 1'b0;
    cmd_v_i       = 1'b0;
    cmd_dest_i    = '0;
    cmd_count_i   = '0;
    cmd_payload_i = '0;
    cmd_gap_i     = '0;
    yumi_i        = 1'b0;
    #2;
    chk("rst_v", 32'(v_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_done", 32'(done_o), 0);
    chk("rst_total", 32'(sent_total_o), 0);
    chk("rst_data", 32'(data_o), 0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rst_ready", 32'(cmd_ready_o), 1);
    @(negedge clk);

    run_burst(1, 3, 14, 0, 0);   // loopback dest, payload wraps E,F,0
    run_burst(2, 2, 5, 0, 2);    // backpressure
    run_burst(3, 2, 9, 3, 0);    // gap pattern 1,0,0,0,1
    run_burst(0, 0, 7, 2, 0);    // zero count

    yumi_i = 1'b1;
    @(negedge clk);
    yumi_i = 1'b0;
    chk("idle_yumi_total", 32'(sent_total_o), model_total);
    chk("idle_yumi_v", 32'(v_o), 0);

    for (int unsigned i = 0; i < 10; i++)
      run_burst($urandom_range(0, 3), $urandom_range(0, 6), $urandom_range(0, 15),
                $urandom_range(0, 3), 1);

    cmd_v_i       = 1'b1;
    cmd_dest_i    = 2'd2;
    cmd_count_i   = 8'd5;
    cmd_payload_i = 4'd3;
    cmd_gap_i     = 4'd0;
    yumi_i        = 1'b1;
    @(negedge clk);
    cmd_v_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_total", 32'(sent_total_o), (model_total + 2) % 65536);
    chk("pre_rst_v", 32'(v_o), 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_v", 32'(v_o), 0);
    chk("async_busy", 32'(busy_o), 0);
    chk("async_data", 32'(data_o), 0);
    chk("async_total", 32'(sent_total_o), 0);
    yumi_i = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    model_total = 0;
    chk("post_rst_ready", 32'(cmd_ready_o), 1);
    chk("post_rst_total", 32'(sent_total_o), 0);
    chk("post_rst_busy", 32'(busy_o), 0);
    @(negedge clk);

    for (int unsigned j = 0; j < 3; j++)
      run_burst($urandom_range(0, 3), $urandom_range(1, 6), $urandom_range(0, 15),
                $urandom_range(0, 2), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
